// File: rtl/bram_controller.sv
// Capture controller: decimated sample capture into an inferred simple
// dual-port RAM, with synchronous read-first readback on a separate address.
module bram_controller #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
) (
  input  logic              pdh_clk,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [25:0]       divcode_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned DIV_W = 26;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  cnt_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              tick_c;
  logic              last_c;
  logic              we_c;

  // Sample strobe: every clock for divcode 0/1, else when the counter reaches divcode-1.
  always_comb begin
    tick_c = (div_q <= DIV_W'(1)) || (cnt_q == (div_q - DIV_W'(1)));
    last_c = &waddr_o;
  end

  // Next-state and write-enable decode.
  always_comb begin
    state_next = state;
    we_c       = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable_i) state_next = CAPTURE;
      end
      CAPTURE: begin
        if (!enable_i) begin
          state_next = IDLE;
        end else if (tick_c) begin
          we_c = 1'b1;
          if (last_c) state_next = DONE;
        end
      end
      DONE: begin
        if (!enable_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register with registered status flags decoded from the next state.
  always_ff @(posedge pdh_clk or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state  <= state_next;
      busy_o <= (state_next == CAPTURE);
      done_o <= (state_next == DONE);
    end
  end

  // Capture datapath: latch divcode on arm, run decimation counter and write address.
  always_ff @(posedge pdh_clk or posedge rst_i) begin
    if (rst_i) begin
      div_q   <= '0;
      cnt_q   <= '0;
      waddr_o <= '0;
    end else if (state == IDLE && enable_i) begin
      div_q   <= divcode_i;
      cnt_q   <= '0;
      waddr_o <= '0;
    end else if (state == CAPTURE && enable_i) begin
      if (we_c) begin
        cnt_q   <= '0;
        waddr_o <= waddr_o + ADDR_W'(1);
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
      end
    end
  end

  // RAM write port; contents are intentionally not reset.
  always_ff @(posedge pdh_clk) begin
    if (we_c) mem[waddr_o] <= data_i;
  end

  // RAM read port: one-clock latency, returns old data on a same-edge collision.
  always_ff @(posedge pdh_clk or posedge rst_i) begin
    if (rst_i) rdata_o <= '0;
    else       rdata_o <= mem[raddr_i];
  end

endmodule

// File: tb/tb_bram_controller.sv
// Self-checking bench for bram_controller: a phase/elapsed-time model of the
// capture plus directed scenarios with hand-computed expectations.
module tb_bram_controller;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              pdh_clk = 1'b0;
  logic              rst_i   = 1'b1;
  logic              enable_i = 1'b0;
  logic [25:0]       divcode_i;
  logic [DATA_W-1:0] data_i = '0;
  logic [ADDR_W-1:0] raddr_i;
  logic [DATA_W-1:0] rdata_o;
  logic [ADDR_W-1:0] waddr_o;
  logic              busy_o;
  logic              done_o;

  bram_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .pdh_clk  (pdh_clk),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .divcode_i(divcode_i),
    .data_i   (data_i),
    .raddr_i  (raddr_i),
    .rdata_o  (rdata_o),
    .waddr_o  (waddr_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 pdh_clk = ~pdh_clk;

  // Free-running sample source: a new value every clock.
  always @(negedge pdh_clk) data_i = data_i + 32'd1;

  int n_cmp = 0;
  int n_err = 0;
  bit run_cmp = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 capturing, 2 done; writes land every period clocks after entry.
  int                m_phase   = 0;
  int                m_period  = 1;
  int                m_elapsed = 0;
  int                m_wa      = 0;
  bit                m_wa_known = 1'b1;
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_valid [DEPTH];
  logic [DATA_W-1:0] m_rdata = '0;
  bit                m_rvalid = 1'b1;

  always @(posedge pdh_clk or posedge rst_i) begin
    if (rst_i) begin
      m_phase = 0; m_wa = 0; m_wa_known = 1'b1; m_elapsed = 0;
      m_rdata = '0; m_rvalid = 1'b1;
    end else begin
      if ($isunknown(raddr_i)) m_rvalid = 1'b0;
      else begin
        m_rvalid = m_valid[raddr_i];
        m_rdata  = m_mem[raddr_i];
      end
      case (m_phase)
        0: if (enable_i === 1'b1) begin
             m_phase = 1; m_elapsed = 0; m_wa = 0; m_wa_known = 1'b1;
             m_period = (divcode_i == 26'd0) ? 1 : int'(divcode_i);
           end
        1: if (enable_i !== 1'b1) begin
             m_phase = 0; m_wa_known = 1'b0;
           end else begin
             m_elapsed++;
             if (m_elapsed % m_period == 0) begin
               m_mem[m_wa] = data_i; m_valid[m_wa] = 1'b1; m_wa++;
               if (m_wa == DEPTH) begin m_wa = 0; m_phase = 2; end
             end
           end
        default: if (enable_i !== 1'b1) m_phase = 0;
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge pdh_clk) begin
    if (run_cmp && !rst_i) begin
      check("busy", 64'(busy_o), 64'(m_phase == 1));
      check("done", 64'(done_o), 64'(m_phase == 2));
      if (m_wa_known) check("waddr", 64'(waddr_o), 64'(m_wa));
      if (m_rvalid)   check("rdata", 64'(rdata_o), 64'(m_rdata));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge pdh_clk);
  endtask

  task automatic wait_waddr(input string name, input logic [ADDR_W-1:0] target, input int bound);
    int i;
    for (i = 0; i < bound && waddr_o != target; i++) tick(1);
    check(name, 64'(waddr_o), 64'(target));
  endtask

  initial begin
    int gap;
    int bad;
    logic [DATA_W-1:0] prev;

    divcode_i = 'x;
    raddr_i   = 'x;
    #12;
    check("rst_busy",  64'(busy_o),  64'd0);
    check("rst_done",  64'(done_o),  64'd0);
    check("rst_waddr", 64'(waddr_o), 64'd0);
    check("rst_rdata", 64'(rdata_o), 64'd0);
    rst_i = 1'b0;
    run_cmp = 1'b1;
    tick(4);
    check("idle_no_enable", 64'(busy_o), 64'd0);

    // Decimation by 3 for 100 clocks.
    divcode_i = 26'd3; enable_i = 1'b1; raddr_i = '0;
    tick(1);
    check("busy_after_enable", 64'(busy_o), 64'd1);
    tick(99);
    check("div3_waddr_100", 64'(waddr_o), 64'd33);
    check("div3_no_done", 64'(done_o), 64'd0);
    enable_i = 1'b0;
    tick(2);

    // Abort at waddr 10, then read back what was written.
    divcode_i = 26'd1; enable_i = 1'b1;
    tick(1);
    wait_waddr("reach_w10", ADDR_W'(10), 50);
    enable_i = 1'b0;
    tick(1);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_done", 64'(done_o), 64'd0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      raddr_i = ADDR_W'(k);
      tick(1);
      if (k > 0 && rdata_o != prev + 32'd1) bad++;
      prev = rdata_o;
    end
    check("abort_ram_consecutive", 64'(bad), 64'd0);

    // Decimation by 5 with divcode changed mid-capture.
    divcode_i = 26'd5; enable_i = 1'b1;
    wait_waddr("div5_first", ADDR_W'(1), 20);
    divcode_i = 26'd1;
    gap = 0;
    do begin tick(1); gap++; end while (waddr_o != ADDR_W'(2) && gap < 20);
    check("div5_spacing", 64'(gap), 64'd5);
    enable_i = 1'b0;
    tick(2);

    // Full capture at one sample per clock.
    divcode_i = 26'd0; enable_i = 1'b1; raddr_i = ADDR_W'(7);
    gap = 0;
    do begin tick(1); gap++; end while (!done_o && gap < 2200);
    check("full_done_clocks", 64'(gap), 64'd2049);
    check("full_done", 64'(done_o), 64'd1);
    check("full_busy", 64'(busy_o), 64'd0);
    check("full_waddr_wrap", 64'(waddr_o), 64'd0);

    // Hold DONE, sweep readback, then release and re-arm.
    tick(50);
    check("done_held", 64'(done_o), 64'd1);
    bad = 0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      raddr_i = ADDR_W'(k);
      tick(1);
      if (k > 0 && rdata_o != prev + 32'd1) bad++;
      prev = rdata_o;
    end
    check("full_ram_consecutive", 64'(bad), 64'd0);
    check("done_after_sweep", 64'(done_o), 64'd1);
    enable_i = 1'b0;
    tick(1);
    check("release_done", 64'(done_o), 64'd0);
    check("release_busy", 64'(busy_o), 64'd0);
    tick(3);
    enable_i = 1'b1;
    tick(1);
    check("rearm_busy", 64'(busy_o), 64'd1);
    check("rearm_waddr", 64'(waddr_o), 64'd0);

    // Asynchronous reset between edges mid-capture.
    tick(20);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_busy",  64'(busy_o),  64'd0);
    check("async_rst_waddr", 64'(waddr_o), 64'd0);
    check("async_rst_done",  64'(done_o),  64'd0);
    tick(1);
    rst_i = 1'b0; enable_i = 1'b0;
    for (int k = 18; k < 30; k++) begin
      raddr_i = ADDR_W'(k);
      tick(1);
    end
    check("post_rst_idle_waddr", 64'(waddr_o), 64'd0);
    check("post_rst_idle_busy",  64'(busy_o),  64'd0);
    divcode_i = 26'd2; enable_i = 1'b1;
    tick(5);
    check("restart_busy",  64'(busy_o),  64'd1);
    check("restart_waddr", 64'(waddr_o), 64'd2);
    enable_i = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
